// File: rtl/fifo_enq_arbiter.sv
// rtl/fifo_enq_arbiter.sv - round-robin arbiter sharing one FIFO write port among NUM_REQ packet streams
module fifo_enq_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]       req_last,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     fifo_wrreq,
  output logic [WIDTH-1:0]         fifo_data,
  input  logic                     fifo_full,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
  localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);
  localparam logic [IW:0] NREQ = (IW + 1)'(NUM_REQ);
  localparam logic [IW-1:0] TOP_IDX = IW'(NUM_REQ - 1);

  logic [0:0]         state;
  logic [NUM_REQ-1:0] grantReg;
  logic [IW-1:0]      rrPtr;
  logic [7:0]         beatCnt;
  logic [IW-1:0]      sel;
  logic [IW-1:0]      gIdx;
  logic               beat;
  logic               endGrant;
  logic [WIDTH-1:0]   words [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign words[i] = req_data[i*WIDTH +: WIDTH];
  end

  // Scan from the far end back toward rrPtr so the nearest valid requester wins.
  always_comb begin : sel_scan
    logic [IW:0] pos;
    sel = rrPtr;
    pos = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = {1'b0, rrPtr} + (IW + 1)'(k);
      if (pos >= NREQ) pos = pos - NREQ;
      if (req_valid[pos[IW-1:0]]) sel = pos[IW-1:0];
    end
  end

  always_comb begin
    gIdx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grantReg[i]) gIdx = IW'(i);
    end
  end

  assign busy       = (state == GRANT);
  assign grant      = grantReg;
  assign req_ready  = (busy && !fifo_full) ? grantReg : '0;
  assign fifo_data  = words[gIdx];
  assign beat       = busy && req_valid[gIdx] && !fifo_full;
  assign fifo_wrreq = beat;
  assign endGrant   = beat && (req_last[gIdx] || (beatCnt == LAST_BEAT));

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      grantReg <= '0;
      rrPtr    <= '0;
      beatCnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            state    <= GRANT;
            grantReg <= {{(NUM_REQ-1){1'b0}}, 1'b1} << sel;
            beatCnt  <= '0;
          end
        end
        default: begin
          if (endGrant) begin
            state    <= IDLE;
            grantReg <= '0;
            rrPtr    <= (gIdx == TOP_IDX) ? '0 : gIdx + 1'b1;
            beatCnt  <= '0;
          end else if (beat) begin
            beatCnt  <= beatCnt + 8'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_enq_arbiter.sv
// tb/tb_fifo_enq_arbiter.sv - self-checking bench for fifo_enq_arbiter with a queue-based FIFO and arbiter model
module tb_fifo_enq_arbiter;
  localparam int N = 4;
  localparam int W = 16;
  localparam int MB = 4;
  localparam int DEPTH = 16;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic           fifo_wrreq;
  logic [W-1:0]   fifo_data;
  logic           fifo_full = 1'b0;
  logic [N-1:0]   grant;
  logic           busy;

  fifo_enq_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_wrreq(fifo_wrreq),
    .fifo_data(fifo_data), .fifo_full(fifo_full), .grant(grant), .busy(busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int fails = 0;

  logic [W-1:0] wq [N][$];
  bit           lq [N][$];
  bit           held [N];
  bit           mask [N];
  bit           bubbly = 0;
  bit           readEn = 0;
  logic [W-1:0] fifoQ[$];
  logic [W-1:0] outQ[$];
  logic [W-1:0] popLog[$];
  int           ownerLog[$];

  // Model: who owns the port, where the round-robin scan starts, beats taken this grant.
  int owner = -1;
  int ptr = 0;
  int beats = 0;

  logic [N-1:0] sGrant;
  logic         sBusy;
  logic         sWr;
  logic [W-1:0] sData;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int oneHotIdx(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic step();
    logic [N-1:0] eGrant, eReady;
    logic         eBusy, eWr, dutWr, doPop, lastFlag;
    logic [W-1:0] dutData, v;
    for (int r = 0; r < N; r++) begin
      if (!held[r])
        req_valid[r] = (wq[r].size() > 0) && !mask[r] && (!bubbly || $urandom_range(3) != 0);
      if (wq[r].size() > 0) begin
        req_data[r*W +: W] = wq[r][0];
        req_last[r] = lq[r][0];
      end else begin
        req_data[r*W +: W] = W'($urandom);
        req_last[r] = 1'($urandom);
      end
    end
    fifo_full = (fifoQ.size() >= DEPTH);
    @(negedge clock);
    eBusy = (owner >= 0);
    eGrant = '0;
    if (eBusy) eGrant[owner] = 1'b1;
    eReady = (eBusy && !fifo_full) ? eGrant : '0;
    eWr = eBusy && req_valid[owner] && !fifo_full;
    chk("grant", grant, eGrant);
    chk("busy", busy, eBusy);
    chk("req_ready", req_ready, eReady);
    chk("fifo_wrreq", fifo_wrreq, eWr);
    chk("no write while full", fifo_wrreq & fifo_full, 0);
    if (eWr) chk("fifo_data", fifo_data, wq[owner][0]);
    sGrant = grant; sBusy = busy; sWr = fifo_wrreq; sData = fifo_data;
    if (fifo_wrreq) ownerLog.push_back(oneHotIdx(grant));
    lastFlag = 1'b0;
    if (eWr) begin
      outQ.push_back(wq[owner].pop_front());
      lastFlag = lq[owner].pop_front();
      beats++;
    end
    for (int r = 0; r < N; r++) held[r] = req_valid[r] && !(eWr && r == owner);
    if (reset) begin
      owner = -1; ptr = 0; beats = 0;
    end else if (owner < 0) begin
      for (int k = 0; k < N; k++) begin
        if (owner < 0 && req_valid[(ptr + k) % N]) owner = (ptr + k) % N;
      end
      beats = 0;
    end else if (eWr && (lastFlag || beats == MB)) begin
      ptr = (owner + 1) % N;
      owner = -1;
    end
    dutWr = fifo_wrreq;
    dutData = fifo_data;
    doPop = readEn && (fifoQ.size() > 0);
    @(posedge clock);
    #1;
    if (doPop) begin
      v = fifoQ.pop_front();
      popLog.push_back(v);
      if (outQ.size() > 0) chk("dequeue order", v, outQ.pop_front());
      else chk("dequeue without expected word", 1, 0);
    end
    if (dutWr) fifoQ.push_back(dutData);
  endtask

  task automatic clearReqs();
    for (int r = 0; r < N; r++) begin
      wq[r].delete(); lq[r].delete(); held[r] = 0; mask[r] = 0;
      req_valid[r] = 1'b0;
    end
  endtask

  task automatic doReset(input int n);
    reset = 1'b1;
    repeat (n) step();
    reset = 1'b0;
    clearReqs();
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    readEn = 1;
    while ((fifoQ.size() > 0) && guard < 200) begin
      step();
      guard++;
    end
    chk("drain fifo empty", fifoQ.size(), 0);
    chk("drain all expected seen", outQ.size(), 0);
  endtask

  task automatic addWord(input int r, input logic [W-1:0] d, input bit l);
    wq[r].push_back(d);
    lq[r].push_back(l);
  endtask

  int seq = 0;

  initial begin
    clearReqs();
    reset = 1'b1;
    repeat (3) step();
    chk("reset grant", sGrant, 0);
    chk("reset busy", sBusy, 0);
    chk("reset req_ready", req_ready, 0);
    chk("reset fifo_wrreq", sWr, 0);
    reset = 1'b0;

    // Single requester, three-word packet
    readEn = 0;
    addWord(1, 16'h00A1, 0); addWord(1, 16'h00A2, 0); addWord(1, 16'h00A3, 1);
    step();
    chk("t1 idle first", sGrant, 0);
    step();
    chk("t1 grant", sGrant, 4'b0010);
    chk("t1 beat1", sData, 16'h00A1);
    step();
    chk("t1 beat2", sData, 16'h00A2);
    step();
    chk("t1 beat3", sData, 16'h00A3);
    chk("t1 beat3 wr", sWr, 1);
    step();
    chk("t1 busy after", sBusy, 0);
    chk("t1 rr_ptr", dut.rrPtr, 2);
    popLog.delete();
    drain();
    chk("t1 readback count", popLog.size(), 3);
    if (popLog.size() == 3) begin
      chk("t1 read0", popLog[0], 16'h00A1);
      chk("t1 read1", popLog[1], 16'h00A2);
      chk("t1 read2", popLog[2], 16'h00A3);
    end

    // Fairness with one-word packets
    doReset(2);
    ownerLog.delete();
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < N; r++) addWord(r, W'(16'h0100 * r + p), 1);
    repeat (20) step();
    chk("fair count", ownerLog.size(), 8);
    for (int i = 0; i < 8 && i < ownerLog.size(); i++) chk("fair order", ownerLog[i], i % 4);
    drain();

    // Burst limit
    begin
      int expB[12] = '{0, 0, 0, 0, 2, 2, 0, 0, 0, 0, 0, 0};
      doReset(2);
      ownerLog.delete();
      for (int i = 0; i < 10; i++) addWord(0, W'(16'h0B00 + i), 0);
      addWord(2, 16'h2B00, 0); addWord(2, 16'h2B01, 1);
      repeat (30) step();
      chk("burst count", ownerLog.size(), 12);
      for (int i = 0; i < 12 && i < ownerLog.size(); i++) chk("burst owner", ownerLog[i], expB[i]);
      doReset(1);
      drain();
    end

    // Backpressure: read side stalled for 40 cycles
    doReset(2);
    readEn = 0;
    for (int i = 0; i < 25; i++) addWord(0, W'(i), (i % 4 == 3) || (i == 24));
    repeat (40) step();
    chk("bp fill level", fifoQ.size(), DEPTH);
    popLog.delete();
    readEn = 1;
    repeat (60) step();
    chk("bp count", popLog.size(), 25);
    for (int i = 0; i < 25 && i < popLog.size(); i++) chk("bp value", popLog[i], i);
    drain();

    // Bubble mid-packet while others wait
    doReset(2);
    readEn = 1;
    for (int i = 0; i < 4; i++) addWord(1, W'(16'h1C00 + i), i == 3);
    step(); step(); step();
    addWord(0, 16'h0C00, 1); addWord(2, 16'h2C00, 1);
    mask[1] = 1;
    repeat (3) begin
      step();
      chk("bubble grant held", sGrant, 4'b0010);
      chk("bubble no write", sWr, 0);
    end
    mask[1] = 0;
    step();
    chk("bubble resume grant", sGrant, 4'b0010);
    chk("bubble resume data", sData, 16'h1C02);
    step();
    chk("bubble last data", sData, 16'h1C03);
    step();
    chk("bubble idle", sBusy, 0);
    step();
    chk("bubble next owner", sGrant, 4'b0100);
    repeat (6) step();
    drain();

    // Reset mid-packet
    doReset(2);
    popLog.delete();
    readEn = 0;
    for (int i = 0; i < 4; i++) addWord(3, W'(16'h3D00 + i), i == 3);
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    clearReqs();
    step();
    chk("rst grant", sGrant, 0);
    chk("rst busy", sBusy, 0);
    chk("rst req_ready", req_ready, 0);
    chk("rst rr_ptr", dut.rrPtr, 0);
    chk("rst fifo words", fifoQ.size(), 2);
    drain();
    chk("rst read count", popLog.size(), 2);
    if (popLog.size() == 2) begin
      chk("rst read0", popLog[0], 16'h3D00);
      chk("rst read1", popLog[1], 16'h3D01);
    end

    // Randomized traffic with bubbles and read stalls
    doReset(2);
    bubbly = 1;
    for (int c = 0; c < 3000; c++) begin
      for (int r = 0; r < N; r++) begin
        if (wq[r].size() == 0 && $urandom_range(7) == 0) begin
          int len;
          len = $urandom_range(6, 1);
          for (int j = 0; j < len; j++) begin
            addWord(r, W'({r[1:0], 14'(seq)}), j == len - 1);
            seq++;
          end
        end
      end
      readEn = (((c / 50) % 3) == 0) ? 1'b0 : 1'($urandom_range(1));
      step();
    end
    bubbly = 0;
    readEn = 1;
    repeat (300) step();
    chk("random requesters empty", wq[0].size() + wq[1].size() + wq[2].size() + wq[3].size(), 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
